// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide controller for the EX stage.
// A shift-add multiplier and a restoring divider each produce one result bit
// per cycle. The unit holds the pipeline with stall while an operation is in
// flight and reports completion with a one-cycle done pulse.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   start   operation request from EX, accepted only in idle
//   funct3  M-op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a    rs1 value (multiplicand / dividend)
//   op_b    rs2 value (multiplier / divisor)
//   flush   abort the in-flight operation
//   busy    operation in flight
//   stall   combinational hold request to the IF/ID/EX registers
//   done    one-cycle result-valid pulse
//   result  operation result, held until the next accepted start
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned    CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     quot_q, quot_d;     // dividend shifts out, quotient shifts in
    logic                neg_q, neg_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand preparation in idle
    logic            is_div;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;

    // Sign correction
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        is_div   = funct3[2];
        // MULH and MULHSU treat rs1 as signed; DIV and REM treat both as signed.
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && ~funct3[0] && (op_a == MinInt) && (op_b == AllOnes);

        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, quot_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};

        prod_fix = neg_q ? -prod_q : prod_q;
        quot_fix = neg_q ? -quot_q : quot_q;
        rem_fix  = neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    f3_d  = funct3;
                    cnt_d = '0;
                    if (is_div) begin
                        opnd_d = b_mag;
                        quot_d = a_mag;
                        rem_d  = '0;
                        // Quotient negative on sign mismatch; remainder follows dividend.
                        neg_d  = funct3[1] ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        opnd_d = a_mag;
                        prod_d = {{XLEN{1'b0}}, b_mag};
                        neg_d  = a_neg ^ b_neg;
                    end
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : AllOnes;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : MinInt;
                        state_d  = StDone;
                    end else begin
                        result_d = '0;
                        state_d  = is_div ? StDiv : StMul;
                    end
                end
            end
            StMul: begin
                prod_d = {mul_sum, prod_q[XLEN-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StDiv: begin
                // Non-negative trial difference means the divisor fits: keep it, set bit.
                if (!div_trial[XLEN]) begin
                    rem_d = div_trial[XLEN-1:0];
                end else begin
                    rem_d = div_shift[XLEN-1:0];
                end
                quot_d = {quot_q[XLEN-2:0], ~div_trial[XLEN]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StFix: begin
                if (f3_q[2]) begin
                    result_d = f3_q[1] ? rem_fix : quot_fix;
                end else begin
                    result_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                    : prod_fix[2*XLEN-1:XLEN];
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort: drop back to idle with the previous result kept intact.
        if (flush && (state_q != StIdle)) begin
            state_d  = StIdle;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            f3_q     <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign stall  = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix) ||
                    ((state_q == StIdle) && start);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed bench for muldiv_sequencer.
// Results are predicted with plain 64-bit arithmetic following RV32M rules.
module tb_muldiv_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    int total;
    int bad;
    logic [31:0] last_res;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b000: begin p = ua * ub;            return p[31:0];  end
            3'b001: begin p = sa * sb;            return p[63:32]; end
            3'b010: begin p = sa * longint'(ub);  return p[63:32]; end
            3'b011: begin p = ua * ub;            return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Wait (bounded) for done; n is the cycle index after the accepting edge.
    task automatic wait_done(output int n, output int stalls);
        n = 1;
        stalls = 0;
        while (!done && n < 60) begin
            if (stall) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        int          n;
        int          stalls;
        exp = ref_result(f, a, b);
        lat = ref_latency(f, a, b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        check_eq("stall_on_start", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        wait_done(n, stalls);
        check_eq($sformatf("latency f3=%0d", f), n, lat);
        check_eq("stall_cycles", stalls, lat - 1);
        check_eq("stall_in_done", {31'b0, stall}, 32'd0);
        check_eq($sformatf("result f3=%0d a=%h b=%h", f, a, b), result, exp);
        @(posedge clk);
        #1;
        check_eq("done_pulse_width", {31'b0, done}, 32'd0);
        check_eq("busy_after_done", {31'b0, busy}, 32'd0);
        check_eq("result_held", result, exp);
        last_res = exp;
    endtask

    initial begin
        int n;
        int stalls;
        int done_cnt;
        total    = 0;
        bad      = 0;
        last_res = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = 3'b000;
        op_a     = '0;
        op_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op(3'b101, 32'd100, 32'd7);
        run_op(3'b111, 32'd100, 32'd7);
        run_op(3'b100, 32'd5, 32'd0);
        run_op(3'b111, 32'd5, 32'd0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush at iteration 10 of a DIV
        funct3 = 3'b100;
        op_a   = 32'h1234_5678;
        op_b   = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy", {31'b0, busy}, 32'd0);
        check_eq("flush_done", {31'b0, done}, 32'd0);
        check_eq("flush_result", result, last_res);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("flush_no_done", done_cnt, 0);
        run_op(3'b100, 32'h1234_5678, 32'd3);

        // flush in idle blocks start
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check_eq("idle_flush_busy", {31'b0, busy}, 32'd0);

        // start while busy is ignored
        funct3 = 3'b000;
        op_a   = 32'd7;
        op_b   = 32'hFFFF_FFFD;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, stalls);
        check_eq("busy_start_latency", n + 4, XLEN + 2);
        check_eq("busy_start_result", result, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        last_res = 32'hFFFF_FFEB;

        // Reset mid-MUL
        funct3 = 3'b011;
        op_a   = 32'hDEAD_BEEF;
        op_b   = 32'h1234_5678;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("midrst_busy", {31'b0, busy}, 32'd0);
        check_eq("midrst_done", {31'b0, done}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("midrst_no_done", done_cnt, 0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom), pick_operand(), pick_operand());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
